// File: rtl/btn_debounce_if.sv
// Signal bundle between a push-button pin and its debouncer.
// The master side owns the raw button; the slave side produces the conditioned outputs.
interface btn_debounce_if;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic       hold_active;
  logic [7:0] press_count;

  modport master (
    output btn_in,
    input  btn_level, press_pulse, release_pulse, long_pulse, hold_active, press_count
  );

  modport slave (
    input  btn_in,
    output btn_level, press_pulse, release_pulse, long_pulse, hold_active, press_count
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, debounce FSM, press/release/long-press
// strobes, hold indicator and a wrapping press counter. All outputs are registered.
module btn_debounce #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic           clk,
  input  logic           rst,
  btn_debounce_if.slave  bus
);

  localparam int DB_CYCLES   = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYCLES = CLK_HZ / 1000 * LONG_MS;
  localparam int DB_W        = $clog2(DB_CYCLES + 1);
  localparam int LONG_W      = $clog2(LONG_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);
  // long_pulse is raised on the edge where hold_cnt steps onto LONG_CYCLES-1.
  localparam logic [LONG_W-1:0] LONG_PRE = LONG_W'(LONG_CYCLES - 2);

  if (DB_CYCLES < 1 || LONG_CYCLES <= DB_CYCLES) begin : g_bad_params
    $error("btn_debounce: need DB_CYCLES >= 1 and LONG_CYCLES > DB_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  state_e              state_q,         state_d;
  logic [1:0]          sync_q,          sync_d;
  logic [DB_W-1:0]     db_cnt_q,        db_cnt_d;
  logic [LONG_W-1:0]   hold_cnt_q,      hold_cnt_d;
  logic                level_q,         level_d;
  logic                press_pulse_q,   press_pulse_d;
  logic                release_pulse_q, release_pulse_d;
  logic                long_pulse_q,    long_pulse_d;
  logic                hold_active_q,   hold_active_d;
  logic [7:0]          press_count_q,   press_count_d;

  logic btn_s;
  assign btn_s = sync_q[1];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d         = state_q;
    sync_d          = {sync_q[0], bus.btn_in};
    db_cnt_d        = db_cnt_q;
    hold_cnt_d      = hold_cnt_q;
    level_d         = level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;
    hold_active_d   = hold_active_q;
    press_count_d   = press_count_q;

    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end

      PRESS_WAIT: begin
        if (!btn_s) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d       = PRESSED;
          db_cnt_d      = '0;
          level_d       = 1'b1;
          press_pulse_d = 1'b1;
          press_count_d = press_count_q + 8'd1;
          hold_cnt_d    = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      PRESSED: begin
        if (hold_cnt_q != LONG_MAX) hold_cnt_d = hold_cnt_q + 1'b1;
        if (hold_cnt_q == LONG_PRE) begin
          long_pulse_d  = 1'b1;
          hold_active_d = 1'b1;
        end
        if (!btn_s) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end
      end

      RELEASE_WAIT: begin
        // hold_cnt stays frozen here so a release bounce only delays long_pulse.
        if (btn_s) begin
          state_d  = PRESSED;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d         = IDLE;
          db_cnt_d        = '0;
          level_d         = 1'b0;
          release_pulse_d = 1'b1;
          hold_active_d   = 1'b0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments; reset is synchronous, tested inside the clocked block.
    if (rst) begin
      state_q         <= IDLE;
      sync_q          <= '0;
      db_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      level_q         <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      hold_active_q   <= 1'b0;
      press_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      sync_q          <= sync_d;
      db_cnt_q        <= db_cnt_d;
      hold_cnt_q      <= hold_cnt_d;
      level_q         <= level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      hold_active_q   <= hold_active_d;
      press_count_q   <= press_count_d;
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_pulse_q;
  assign bus.release_pulse = release_pulse_q;
  assign bus.long_pulse    = long_pulse_q;
  assign bus.hold_active   = hold_active_q;
  assign bus.press_count   = press_count_q;

endmodule
